// File: rtl/jpeg_pkg.sv
// Shared JPEG entropy-coding constants, packer FSM states and code-length helper.
package jpeg_pkg;

  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;
  localparam int         HUFF_CODE_MAX_LEN  = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAD   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pack_state_t;

  // Out-of-range lengths (33..63) are clamped to the widest legal code.
  function automatic logic [5:0] sat_len(input logic [5:0] len);
    return (len > 6'(HUFF_CODE_MAX_LEN)) ? 6'(HUFF_CODE_MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/jpeg_bitstream_packer_if.sv
// Code-stream input, flush control and byte output handshake of the bitstream packer.
interface jpeg_bitstream_packer_if;

  logic        input_wren;
  logic [5:0]  input_length;
  logic [31:0] input_data;
  logic        flush;
  logic        stall;
  logic        output_valid;
  logic [7:0]  output_byte;
  logic        output_ready;
  logic        flush_done;

  modport master (
    output input_wren, input_length, input_data, flush, output_ready,
    input  stall, output_valid, output_byte, flush_done
  );

  modport slave (
    input  input_wren, input_length, input_data, flush, output_ready,
    output stall, output_valid, output_byte, flush_done
  );

endinterface

// File: rtl/jpeg_byte_stuffer.sv
// Output byte register with valid/ready handshake; inserts 0x00 after every 0xFF.
// Latency 1 cycle from byte_vld; holds output_byte/output_valid while !output_ready.
module jpeg_byte_stuffer
  import jpeg_pkg::*;
#(
  parameter bit stuff_enable = 1'b1
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       byte_vld,
  input  logic [7:0] byte_dat,
  output logic       byte_take,
  output logic       idle,
  output logic       output_valid,
  output logic [7:0] output_byte,
  input  logic       output_ready
);

  logic stuff_pending;
  logic reg_free;

  assign reg_free  = !output_valid | output_ready;
  assign byte_take = reg_free & !stuff_pending & byte_vld;
  assign idle      = reg_free & !stuff_pending;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      output_valid  <= 1'b0;
      output_byte   <= 8'h00;
      stuff_pending <= 1'b0;
    end else if (reg_free) begin
      if (stuff_pending) begin
        output_valid  <= 1'b1;
        output_byte   <= JPEG_STUFF_BYTE;
        stuff_pending <= 1'b0;
      end else if (byte_vld) begin
        output_valid  <= 1'b1;
        output_byte   <= byte_dat;
        stuff_pending <= stuff_enable && (byte_dat == JPEG_MARKER_PREFIX);
      end else begin
        output_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jpeg_bitstream_packer.sv
// Packs variable-length Huffman codes MSB-first into stuffed bytes; pads and drains on flush.
// Latency 1 cycle per completed byte; stalls the encoder when >32 bits are buffered or flushing.
module jpeg_bitstream_packer
  import jpeg_pkg::*;
#(
  parameter bit stuff_enable = 1'b1,
  parameter bit pad_bit      = 1'b1
) (
  input  logic                    clock,
  input  logic                    nreset,
  jpeg_bitstream_packer_if.slave  bus
);

  localparam logic [63:0] ONES = '1;

  pack_state_t state, state_nxt;
  logic [63:0] bitbuf, buf_shift, buf_nxt, code_aligned, pad_mask;
  logic [6:0]  bitcount, cnt_shift, cnt_nxt, pad_cnt;
  logic [5:0]  code_len;
  logic [31:0] code_mask;
  logic        accept, byte_take, stuffer_idle;

  jpeg_byte_stuffer #(.stuff_enable(stuff_enable)) u_stuffer (
    .clock        (clock),
    .nreset       (nreset),
    .byte_vld     (bitcount >= 7'd8),
    .byte_dat     (bitbuf[63:56]),
    .byte_take    (byte_take),
    .idle         (stuffer_idle),
    .output_valid (bus.output_valid),
    .output_byte  (bus.output_byte),
    .output_ready (bus.output_ready)
  );

  assign accept = bus.input_wren & !bus.stall;

  // Append position is taken after this cycle's byte extraction shift.
  always_comb begin
    code_len     = sat_len(bus.input_length);
    code_mask    = (code_len == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << code_len) - 32'd1);
    code_aligned = {bus.input_data & code_mask, 32'd0} << (7'd32 - {1'b0, code_len});
    buf_shift    = byte_take ? {bitbuf[55:0], 8'd0} : bitbuf;
    cnt_shift    = byte_take ? (bitcount - 7'd8) : bitcount;
    buf_nxt      = buf_shift;
    cnt_nxt      = cnt_shift;
    pad_cnt      = 7'd0;
    pad_mask     = '0;
    if (accept) begin
      buf_nxt = buf_shift | (code_aligned >> cnt_shift);
      cnt_nxt = cnt_shift + {1'b0, code_len};
    end else if (state == PAD && cnt_shift[2:0] != 3'd0) begin
      pad_cnt  = 7'd8 - {4'd0, cnt_shift[2:0]};
      pad_mask = ~(ONES >> (cnt_shift + pad_cnt)) & (ONES >> cnt_shift);
      buf_nxt  = buf_shift | (pad_bit ? pad_mask : 64'd0);
      cnt_nxt  = cnt_shift + pad_cnt;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      bitbuf   <= '0;
      bitcount <= '0;
    end else begin
      bitbuf   <= buf_nxt;
      bitcount <= cnt_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) state <= RUN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.flush && !bus.stall) state_nxt = PAD;
      PAD:     state_nxt = DRAIN;
      DRAIN:   if (bitcount == 7'd0 && stuffer_idle) state_nxt = DONE;
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    bus.stall      = (bitcount > 7'd32) || (state != RUN);
    bus.flush_done = (state == DONE);
  end

endmodule

// File: doc/jpeg_bitstream_packer.md
Name: jpeg_bitstream_packer

Overview:
- Sits directly downstream of jpeg_huffman_encode and consumes its (output_wren, output_length, output_data) variable-length code stream.
- Concatenates codes MSB-first into bytes and inserts 0x00 after every emitted 0xFF (JPEG byte stuffing).
- Pads the final partial byte with 1s on flush and presents bytes to the file/FIFO writer over a valid/ready handshake.
- Drives stall back to the Huffman encoder when its bit buffer cannot absorb another 32-bit code.

Parameters:
- stuff_enable, 1, 1 = insert 0x00 after each 0xFF byte; 0 = pass bytes through unmodified.
- pad_bit, 1, value used to fill the last partial byte on flush.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- nreset  input  1  synchronous, active-low reset.
- input_wren  input  1  code word present (from huff output_wren).
- input_length  input  6  number of valid bits in input_data, 0..32.
- input_data  input  32  code, right-aligned; bit [input_length-1] is sent first.
- flush  input  1  end-of-scan request; pad to a byte boundary and drain.
- stall  output  1  1 = input_wren/flush are not consumed this cycle; producer holds them.
- output_valid  output  1  output_byte is valid.
- output_byte  output  8  packed/stuffed byte.
- output_ready  input  1  consumer accepts output_byte this cycle.
- flush_done  output  1  one-cycle pulse: flush complete, all bytes accepted downstream.

Behaviour:
- Reset, sampled synchronously while nreset = 0:
  - Clears the bit buffer (bitbuf 64 b, left-aligned) and bitcount (7 b, 0..64).
  - Clears the stuff-pending flag and returns the FSM to RUN.
  - Outputs: output_valid = 0, output_byte = 0x00, flush_done = 0, stall = 0.
  - Reset mid-operation discards all buffered bits with no partial output.
- stall is combinational from registers: stall = (bitcount > 32) | (state != RUN).
- Input accept:
  - A word is accepted iff input_wren & !stall.
  - Accepted bits are appended directly after the existing bitcount bits; bitcount += input_length.
  - input_length 0 is a no-op.
  - Lengths 33..63 are illegal; the block saturates them to 32 and the bench flags them.
- Byte extraction into the output register:
  - Occurs when the output register is free, i.e. !output_valid | output_ready.
  - If stuff_pending: load 0x00 and clear stuff_pending. Buffer bytes are not taken that cycle.
  - Else if bitcount >= 8: load bitbuf[63:56], shift left 8, bitcount -= 8. Set stuff_pending if the byte is 0xFF and stuff_enable = 1.
  - Else: output_valid <= 0.
- Extraction and append in the same cycle: the append position is computed after the 8-bit shift, so no bit is lost or duplicated.
- Latency: a byte completed by a word accepted at edge N is valid after edge N+1, provided the output register is free. Throughput is 1 byte/cycle, with stuffing costing 1 extra cycle.
- Backpressure: output_byte and output_valid hold stable while output_valid & !output_ready.
- FSM:
  - RUN: flush & !stall → PAD. An input_wren presented in the same cycle is appended first.
  - PAD (1 cycle): if bitcount mod 8 != 0, fill with pad_bit up to the next multiple of 8. → DRAIN.
  - DRAIN: when bitcount = 0, !stuff_pending and (!output_valid | output_ready) → DONE.
  - DONE (1 cycle): flush_done = 1. → RUN.
- Flush with 0 pending bits adds no pad byte.
- A padded byte that equals 0xFF is stuffed like any other 0xFF.

Decomposition:
- Shared package jpeg_pkg:
  - JPEG_MARKER_PREFIX = 8'hFF, JPEG_STUFF_BYTE = 8'h00.
  - Packer state enum {RUN, PAD, DRAIN, DONE}.
  - HUFF_CODE_MAX_LEN = 32.
- One natural sub-module, jpeg_byte_stuffer: the output register, the valid/ready handshake and stuff_pending insertion. The top level keeps the bit buffer and the FSM.

Test Plan:
1. Hold nreset = 0 for 4 cycles with input_wren = 1, flush = 1 → output_valid = 0, stall = 0, flush_done = 0, no bytes out; after release, the first word is accepted normally.
2. Codes (len 2, 0x0), (len 3, 0x2), (len 3, 0x7) on consecutive cycles, output_ready = 1 → single byte 0x17 one cycle after the third accept; bitcount back to 0.
3. One code (len 16, 0xFF12) → bytes FF, 00, 12 in order, on 3 consecutive valid cycles.
4. (len 5, 0x15) then flush → byte 0xAF, then flush_done pulses exactly once; stall is high from PAD until DONE.
5. output_ready = 0, send 0x01234567 (len 32) twice → stall rises once bitcount > 32 and the held word is not lost; raise output_ready → bytes 01 23 45 67 01 23 45 67, output_byte stable while not ready.
6. (len 4, 0xF) then flush → bytes FF, 00 (stuffed pad byte); then flush with empty buffer → no byte, flush_done 2 edges after flush accept.
